// File: rtl/bet_entry_if.sv
// Bet entry bus: keystroke input, table limits and the valid/ack handshake
// toward the betting FSM, plus the echo outputs for the money display.
interface bet_entry_if #(
    parameter int DIGITS  = 4,
    parameter int VALUE_W = 11
);
    logic                  entry_en;
    logic [7:0]            keycode;
    logic [VALUE_W-1:0]    min_bet;
    logic [VALUE_W-1:0]    max_bet;
    logic                  bet_ack;
    logic [VALUE_W-1:0]    bet_value;
    logic [4*DIGITS-1:0]   bet_digits;
    logic [2:0]            digit_count;
    logic                  bet_valid;
    logic                  entry_error;
    logic                  busy;

    // Betting FSM / keyboard side
    modport master (
        output entry_en, keycode, min_bet, max_bet, bet_ack,
        input  bet_value, bet_digits, digit_count, bet_valid, entry_error, busy
    );

    // bet_entry side
    modport slave (
        input  entry_en, keycode, min_bet, max_bet, bet_ack,
        output bet_value, bet_digits, digit_count, bet_valid, entry_error, busy
    );
endinterface

// File: rtl/bet_entry.sv
// Keyboard-driven bet/raise entry. Decimal keystrokes build an 11-bit amount
// (with a parallel BCD copy for the display), Enter validates it against the
// live table limits and offers it to the betting FSM until acknowledged.
// Optional build macro BET_ENTRY_ALLIN_EN: key 0x04 ('A') loads max_bet and
// rebuilds the BCD digits with a sequential double-dabble.
module bet_entry #(
    parameter int DIGITS     = 4,
    parameter int VALUE_W    = 11,
    parameter int ERR_CYCLES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    bet_entry_if.slave bus
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CAND_W = 14;
    localparam int ERR_W  = $clog2(ERR_CYCLES + 1);

    localparam logic [7:0] KEY_DIG1  = 8'h1E;
    localparam logic [7:0] KEY_DIG0  = 8'h27;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;
`ifdef BET_ENTRY_ALLIN_EN
    localparam logic [7:0] KEY_ALLIN = 8'h04;
    localparam int         DD_CW     = $clog2(VALUE_W + 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_CONFIRM,
        S_ERROR,
        S_CONV
    } state_t;

    state_t               state;
    logic [7:0]           key_q;
    logic [7:0]           key_q2;
    logic [VALUE_W-1:0]   value_r;
    logic [BCD_W-1:0]     digits_r;
    logic [2:0]           count_r;
    logic                 valid_r;
    logic                 err_r;
    logic                 busy_r;
    logic [ERR_W-1:0]     err_cnt;
`ifdef BET_ENTRY_ALLIN_EN
    logic [VALUE_W-1:0]   dd_bin;
    logic [BCD_W-1:0]     dd_bcd;
    logic [DD_CW-1:0]     dd_cnt;
`endif

    // True for the ten digit keys (1..9 then 0, contiguous in HID usage)
    function automatic logic is_digit(input logic [7:0] k);
        return (k >= KEY_DIG1) && (k <= KEY_DIG0);
    endfunction

    // Decimal value of a digit key; 0x27 is zero, 0x1E..0x26 are 1..9
    function automatic logic [3:0] digit_of(input logic [7:0] k);
        logic [7:0] t;
        t = k - 8'h1D;
        return (k == KEY_DIG0) ? 4'd0 : t[3:0];
    endfunction

`ifdef BET_ENTRY_ALLIN_EN
    // One double-dabble iteration: add 3 to nibbles >= 5, then shift in a bit
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                                 input logic             bit_in);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], bit_in};
    endfunction

    // Number of significant digits: position of the highest nonzero nibble
    function automatic logic [2:0] sig_digits(input logic [BCD_W-1:0] bcd);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0)
                n = 3'(i + 1);
        end
        return n;
    endfunction
`endif

    logic               press;
    logic [3:0]         key_val;
    logic [CAND_W-1:0]  cand;
    logic [VALUE_W-1:0] value_div10;
    logic               cand_ok;
    logic               enter_ok;

    // A press is a nonzero code that differs from the previous sample, so a
    // held key fires once and a direct code-to-code change fires again.
    assign press       = (key_q != 8'h00) && (key_q != key_q2);
    assign key_val     = digit_of(key_q);
    assign cand        = CAND_W'(value_r) * CAND_W'(10) + CAND_W'(key_val);
    assign cand_ok     = cand <= CAND_W'(bus.max_bet);
    assign value_div10 = value_r / VALUE_W'(10);
    assign enter_ok    = (count_r != 3'd0) && (value_r >= bus.min_bet) &&
                         (value_r <= bus.max_bet);

    // Entry state machine, key history and all registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= S_IDLE;
            key_q    <= 8'h00;
            key_q2   <= 8'h00;
            value_r  <= '0;
            digits_r <= '0;
            count_r  <= 3'd0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            err_cnt  <= '0;
`ifdef BET_ENTRY_ALLIN_EN
            dd_bin   <= '0;
            dd_bcd   <= '0;
            dd_cnt   <= '0;
`endif
        end else begin
            // History tracks the keyboard in every state so held keys never re-fire
            key_q  <= bus.keycode;
            key_q2 <= key_q;

            if (state != S_IDLE && !bus.entry_en) begin
                // Losing the entry grant wins over ack and any key
                state    <= S_IDLE;
                value_r  <= '0;
                digits_r <= '0;
                count_r  <= 3'd0;
                valid_r  <= 1'b0;
                err_r    <= 1'b0;
                busy_r   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.entry_en) begin
                            state  <= S_ENTRY;
                            busy_r <= 1'b1;
                        end
                    end

                    S_ENTRY: begin
                        if (press) begin
                            if (is_digit(key_q)) begin
                                if (!(count_r == 3'd0 && key_val == 4'd0) &&
                                    count_r != 3'(DIGITS)) begin
                                    if (cand_ok) begin
                                        value_r  <= cand[VALUE_W-1:0];
                                        digits_r <= (digits_r << 4) | BCD_W'(key_val);
                                        count_r  <= count_r + 3'd1;
                                    end else begin
                                        state   <= S_ERROR;
                                        err_r   <= 1'b1;
                                        err_cnt <= ERR_W'(ERR_CYCLES - 1);
                                    end
                                end
                            end else if (key_q == KEY_BKSP) begin
                                if (count_r != 3'd0) begin
                                    value_r  <= value_div10;
                                    digits_r <= digits_r >> 4;
                                    count_r  <= count_r - 3'd1;
                                end
                            end else if (key_q == KEY_ESC) begin
                                value_r  <= '0;
                                digits_r <= '0;
                                count_r  <= 3'd0;
                            end else if (key_q == KEY_ENTER) begin
                                if (enter_ok) begin
                                    state   <= S_CONFIRM;
                                    valid_r <= 1'b1;
                                end else begin
                                    state   <= S_ERROR;
                                    err_r   <= 1'b1;
                                    err_cnt <= ERR_W'(ERR_CYCLES - 1);
                                end
                            end
`ifdef BET_ENTRY_ALLIN_EN
                            else if (key_q == KEY_ALLIN) begin
                                state   <= S_CONV;
                                value_r <= bus.max_bet;
                                dd_bin  <= bus.max_bet;
                                dd_bcd  <= '0;
                                dd_cnt  <= DD_CW'(VALUE_W);
                            end
`endif
                        end
                    end

                    S_CONFIRM: begin
                        if (bus.bet_ack) begin
                            state    <= S_IDLE;
                            valid_r  <= 1'b0;
                            value_r  <= '0;
                            digits_r <= '0;
                            count_r  <= 3'd0;
                            busy_r   <= 1'b0;
                        end
                    end

                    S_ERROR: begin
                        if (err_cnt == '0) begin
                            state <= S_ENTRY;
                            err_r <= 1'b0;
                        end else begin
                            err_cnt <= err_cnt - 1'b1;
                        end
                    end

`ifdef BET_ENTRY_ALLIN_EN
                    S_CONV: begin
                        if (dd_cnt == '0) begin
                            digits_r <= dd_bcd;
                            count_r  <= sig_digits(dd_bcd);
                            state    <= S_ENTRY;
                        end else begin
                            dd_bcd <= dd_step(dd_bcd, dd_bin[VALUE_W-1]);
                            dd_bin <= dd_bin << 1;
                            dd_cnt <= dd_cnt - 1'b1;
                        end
                    end
`endif

                    default: begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bet_value   = value_r;
    assign bus.bet_digits  = digits_r;
    assign bus.digit_count = count_r;
    assign bus.bet_valid   = valid_r;
    assign bus.entry_error = err_r;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_bet_entry.sv
// Testbench for bet_entry: directed scenarios plus randomized keystroke
// sequences checked against a digit-list model of the entered amount.
// Honours BET_ENTRY_ALLIN_EN when the design is built with it.
module tb_bet_entry;
    localparam int DIGITS  = 4;
    localparam int VALUE_W = 11;
    localparam int ERR     = 30;

    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    bet_entry_if #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) bus ();

    bet_entry #(.DIGITS(DIGITS), .VALUE_W(VALUE_W), .ERR_CYCLES(ERR)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Model: the entered digits, most significant first
    int m_digs[$];

    function automatic int m_val();
        int v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        return v;
    endfunction

    function automatic logic [15:0] m_bcd();
        logic [15:0] b = 16'h0;
        foreach (m_digs[i]) b = (b << 4) | 16'(m_digs[i]);
        return b;
    endfunction

    function automatic logic [7:0] code_of(input int d);
        return (d == 0) ? 8'h27 : 8'(8'h1D + d);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Key goes down; after two edges the press has been acted on
    task automatic key_down(input logic [7:0] c);
        bus.keycode = c;
        tick();
        tick();
    endtask

    task automatic key_up();
        bus.keycode = 8'h00;
        tick();
    endtask

    task automatic press(input logic [7:0] c);
        key_down(c);
        key_up();
    endtask

    // Re-grant entry from a clean IDLE so each scenario starts empty
    task automatic go_fresh();
        bus.entry_en = 1'b0;
        bus.bet_ack  = 1'b0;
        bus.keycode  = 8'h00;
        tick();
        bus.entry_en = 1'b1;
        tick();
        m_digs.delete();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        total++; if (bus.bet_value !== 11'd0) begin bad++; $display("FAIL rst_value got=%0d exp=0", bus.bet_value); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.bet_valid !== 1'b0 || bus.entry_error !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b exp=00", bus.bet_valid, bus.entry_error); end
        Reset = 1'b0;
        tick();
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd1000;
        go_fresh();
        press(8'h22);
        press(8'h24);
        total++; if (bus.bet_value !== 11'd57) begin bad++; $display("FAIL rst_pre57 got=%0d exp=57", bus.bet_value); end
        #2 Reset = 1'b1;
        #1;
        total++; if (bus.bet_value !== 11'd0 || bus.bet_digits !== 16'h0 || bus.digit_count !== 3'd0) begin
            bad++; $display("FAIL rst_async got=%0d/%h/%0d exp=0/0000/0", bus.bet_value, bus.bet_digits, bus.digit_count); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%0b exp=0", bus.busy); end
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus.min_bet = 11'd20;
        bus.max_bet = 11'd1000;
        go_fresh();
        press(8'h1F);
        press(8'h22);
        press(8'h27);
        key_down(8'h28);
        total++; if (bus.bet_value !== 11'd250 || bus.bet_digits !== 16'h0250 || bus.digit_count !== 3'd3) begin
            bad++; $display("FAIL basic_val got=%0d/%h/%0d exp=250/0250/3", bus.bet_value, bus.bet_digits, bus.digit_count); end
        total++; if (bus.bet_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", bus.bet_valid); end
        key_up();
        bus.bet_ack = 1'b1;
        tick();
        bus.bet_ack = 1'b0;
        total++; if (bus.bet_valid !== 1'b0 || bus.bet_value !== 11'd0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL basic_ack got=v%0b val%0d busy%0b exp=v0 val0 busy0", bus.bet_valid, bus.bet_value, bus.busy); end
    endtask

    task automatic test_error();
        int n;
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd300;
        go_fresh();
        press(8'h20);
        press(8'h22);
        key_down(8'h27);
        total++; if (bus.entry_error !== 1'b1 || bus.bet_value !== 11'd35) begin
            bad++; $display("FAIL err_enter got=e%0b val%0d exp=e1 val35", bus.entry_error, bus.bet_value); end
        n = 0;
        while (bus.entry_error === 1'b1 && n < 200) begin n++; tick(); end
        total++; if (n != ERR) begin bad++; $display("FAIL err_len got=%0d exp=%0d", n, ERR); end
        key_up();
        total++; if (bus.bet_value !== 11'd35) begin bad++; $display("FAIL err_keep got=%0d exp=35", bus.bet_value); end
        press(8'h2A);
        total++; if (bus.bet_value !== 11'd3 || bus.bet_digits !== 16'h0003 || bus.digit_count !== 3'd1) begin
            bad++; $display("FAIL err_bksp got=%0d/%h/%0d exp=3/0003/1", bus.bet_value, bus.bet_digits, bus.digit_count); end
    endtask

    task automatic test_hold();
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd1000;
        go_fresh();
        bus.keycode = 8'h1F;
        repeat (50) tick();
        total++; if (bus.bet_value !== 11'd2 || bus.digit_count !== 3'd1) begin
            bad++; $display("FAIL hold_once got=%0d/%0d exp=2/1", bus.bet_value, bus.digit_count); end
        bus.keycode = 8'h20;
        tick();
        tick();
        total++; if (bus.bet_value !== 11'd23 || bus.bet_digits !== 16'h0023) begin
            bad++; $display("FAIL hold_change got=%0d/%h exp=23/0023", bus.bet_value, bus.bet_digits); end
        key_up();
    endtask

    task automatic test_enter_reject();
        int  n;
        logic seen;
        bus.min_bet = 11'd20;
        bus.max_bet = 11'd1000;
        go_fresh();
        press(8'h1E);
        press(8'h27);
        key_down(8'h28);
        total++; if (bus.entry_error !== 1'b1) begin bad++; $display("FAIL rej_min got=%0b exp=1", bus.entry_error); end
        n = 0; seen = 1'b0;
        while (bus.entry_error === 1'b1 && n < 200) begin seen = seen | bus.bet_valid; n++; tick(); end
        key_up();
        total++; if (seen !== 1'b0 || bus.bet_valid !== 1'b0) begin bad++; $display("FAIL rej_novalid got=1 exp=0"); end
        total++; if (bus.bet_value !== 11'd10) begin bad++; $display("FAIL rej_keep got=%0d exp=10", bus.bet_value); end
        press(8'h29);
        total++; if (bus.bet_value !== 11'd0 || bus.digit_count !== 3'd0) begin
            bad++; $display("FAIL esc got=%0d/%0d exp=0/0", bus.bet_value, bus.digit_count); end
        key_down(8'h28);
        total++; if (bus.entry_error !== 1'b1) begin bad++; $display("FAIL rej_empty got=%0b exp=1", bus.entry_error); end
        n = 0;
        while (bus.entry_error === 1'b1 && n < 200) begin n++; tick(); end
        total++; if (n != ERR) begin bad++; $display("FAIL rej_empty_len got=%0d exp=%0d", n, ERR); end
        key_up();
        press(8'h27);
        total++; if (bus.digit_count !== 3'd0 || bus.bet_value !== 11'd0) begin
            bad++; $display("FAIL lead0 got=%0d/%0d exp=0/0", bus.digit_count, bus.bet_value); end
    endtask

    task automatic test_abort_confirm();
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd1000;
        go_fresh();
        press(8'h21);
        press(8'h27);
        press(8'h27);
        key_down(8'h28);
        total++; if (bus.bet_valid !== 1'b1 || bus.bet_value !== 11'd400) begin
            bad++; $display("FAIL abort_pre got=v%0b val%0d exp=v1 val400", bus.bet_valid, bus.bet_value); end
        key_up();
        bus.entry_en = 1'b0;
        bus.bet_ack  = 1'b1;
        tick();
        bus.bet_ack  = 1'b0;
        total++; if (bus.bet_valid !== 1'b0 || bus.bet_value !== 11'd0 || bus.bet_digits !== 16'h0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort got=v%0b val%0d dig%h busy%0b exp=0/0/0000/0", bus.bet_valid, bus.bet_value, bus.bet_digits, bus.busy); end
        bus.entry_en = 1'b1;
        tick();
    endtask

`ifdef BET_ENTRY_ALLIN_EN
    task automatic test_allin();
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd1523;
        go_fresh();
        press(8'h04);
        repeat (VALUE_W + 4) tick();
        key_down(8'h28);
        total++; if (bus.bet_digits !== 16'h1523 || bus.bet_value !== 11'd1523 || bus.digit_count !== 3'd4) begin
            bad++; $display("FAIL allin got=%h/%0d/%0d exp=1523/1523/4", bus.bet_digits, bus.bet_value, bus.digit_count); end
        total++; if (bus.bet_valid !== 1'b1) begin bad++; $display("FAIL allin_valid got=%0b exp=1", bus.bet_valid); end
        key_up();
        bus.bet_ack = 1'b1;
        tick();
        bus.bet_ack = 1'b0;
        tick();
    endtask
`else
    task automatic test_allin();
        bus.min_bet = 11'd0;
        bus.max_bet = 11'd1523;
        go_fresh();
        press(8'h04);
        total++; if (bus.bet_value !== 11'd0 || bus.digit_count !== 3'd0 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL allin_ignored got=%0d/%0d/%0b exp=0/0/1", bus.bet_value, bus.digit_count, bus.busy); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] ign [5];
        logic [7:0] code;
        int sel, d, v, n, mx, mn;
        logic exp_err, exp_valid;
        ign[0] = 8'h05; ign[1] = 8'h2B; ign[2] = 8'h1D; ign[3] = 8'h50;
`ifdef BET_ENTRY_ALLIN_EN
        ign[4] = 8'h2C;
`else
        ign[4] = 8'h04;
`endif
        go_fresh();
        for (int i = 0; i < 300; i++) begin
            mx = $urandom_range(2047, 30);
            mn = $urandom_range(mx / 3, 0);
            bus.max_bet = 11'(mx);
            bus.min_bet = 11'(mn);
            sel = $urandom_range(99, 0);
            exp_err = 1'b0;
            exp_valid = 1'b0;
            v = m_val();
            n = m_digs.size();
            if (sel < 60) begin
                d = $urandom_range(9, 0);
                code = code_of(d);
                if (!((n == 0 && d == 0) || n == DIGITS)) begin
                    if (v * 10 + d > mx) exp_err = 1'b1;
                    else m_digs.push_back(d);
                end
            end else if (sel < 72) begin
                code = 8'h28;
                if (n > 0 && v >= mn && v <= mx) exp_valid = 1'b1;
                else exp_err = 1'b1;
            end else if (sel < 84) begin
                code = 8'h2A;
                if (n > 0) void'(m_digs.pop_back());
            end else if (sel < 90) begin
                code = 8'h29;
                m_digs.delete();
            end else begin
                code = ign[$urandom_range(4, 0)];
            end
            key_down(code);
            total++; if (bus.bet_value !== 11'(m_val()) || bus.bet_digits !== m_bcd() || bus.digit_count !== 3'(m_digs.size())) begin
                bad++; $display("FAIL rnd_value[%0d] key=%h got=%0d/%h/%0d exp=%0d/%h/%0d", i, code,
                    bus.bet_value, bus.bet_digits, bus.digit_count, m_val(), m_bcd(), m_digs.size()); end
            total++; if (bus.bet_valid !== exp_valid || bus.entry_error !== exp_err) begin
                bad++; $display("FAIL rnd_flags[%0d] key=%h got=v%0b e%0b exp=v%0b e%0b", i, code,
                    bus.bet_valid, bus.entry_error, exp_valid, exp_err); end
            if (exp_err) begin
                n = 0;
                while (bus.entry_error === 1'b1 && n < 200) begin n++; tick(); end
                total++; if (n != ERR) begin bad++; $display("FAIL rnd_errlen[%0d] got=%0d exp=%0d", i, n, ERR); end
                key_up();
            end else if (exp_valid) begin
                key_up();
                bus.bet_ack = 1'b1;
                tick();
                bus.bet_ack = 1'b0;
                total++; if (bus.bet_valid !== 1'b0 || bus.bet_value !== 11'd0 || bus.busy !== 1'b0) begin
                    bad++; $display("FAIL rnd_ack[%0d] got=v%0b val%0d b%0b exp=0/0/0", i, bus.bet_valid, bus.bet_value, bus.busy); end
                tick();
                m_digs.delete();
            end else begin
                key_up();
            end
        end
    endtask

    initial begin
        Reset        = 1'b1;
        bus.entry_en = 1'b0;
        bus.keycode  = 8'h00;
        bus.min_bet  = 11'd0;
        bus.max_bet  = 11'd0;
        bus.bet_ack  = 1'b0;
        test_reset();
        test_basic();
        test_error();
        test_hold();
        test_enter_reject();
        test_abort_confirm();
        test_allin();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
